u_xmit_queue: RTL and testbench

U_XMIT_QUEUE -- requirements
Module: u_xmit_queue

---
 rtl/u_xmit_queue.sv | 101 ++++++++++
 tb/tb_u_xmit_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_xmit_queue.sv
// UART transmit byte queue: circular FIFO feeding a three-state launch FSM toward the transmitter.
// Optional sticky overflow flag is compiled in with `define UART_TXQ_OVF_EN.
module u_xmit_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_l,
  input  logic                  wr_enH,
  input  logic [7:0]            wr_dataH,
  input  logic                  flushH,
  output logic                  fullH,
  output logic                  emptyH,
  output logic [DEPTH_LOG2:0]   countH,
  output logic                  xmitH,
  output logic [7:0]            xmit_dataH,
  input  logic                  xmit_doneH,
  output logic                  ovf_flagH
);

  localparam int Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_WAITBUSY,
    Q_WAITDONE
  } qState_t;

  qState_t               state;
  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   count;
  logic                  wrAccept;
  logic                  pop;

  assign fullH    = (count == FullCount);
  assign emptyH   = (count == '0);
  assign countH   = count;
  assign wrAccept = wr_enH && !fullH && !flushH;
  assign pop      = (state == Q_IDLE) && !emptyH && xmitH == 1'b0 && xmit_doneH;

  // NOTE: the byte array carries no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge sys_clk) begin
    if (wrAccept) mem[wrPtr] <= wr_dataH;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flushH) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + 1'b1;
      if (pop)      rdPtr <= rdPtr + 1'b1;
      case ({wrAccept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flush deliberately leaves the launch path alone so an in-flight byte completes.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state      <= Q_IDLE;
      xmitH      <= 1'b0;
      xmit_dataH <= 8'h00;
    end else begin
      xmitH <= 1'b0;
      case (state)
        Q_IDLE: begin
          if (pop) begin
            xmit_dataH <= mem[rdPtr];
            xmitH      <= 1'b1;
            state      <= Q_WAITBUSY;
          end
        end
        Q_WAITBUSY: if (!xmit_doneH) state <= Q_WAITDONE;
        Q_WAITDONE: if (xmit_doneH)  state <= Q_IDLE;
        default:    state <= Q_IDLE;
      endcase
    end
  end

`ifdef UART_TXQ_OVF_EN
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l)             ovf_flagH <= 1'b0;
    else if (flushH)            ovf_flagH <= 1'b0;
    else if (wr_enH && fullH)   ovf_flagH <= 1'b1;
  end
`else
  assign ovf_flagH = 1'b0;
`endif

endmodule

// File: tb/tb_u_xmit_queue.sv
// Randomised scoreboard bench for u_xmit_queue against a queue-based reference model.
module tb_u_xmit_queue;

  localparam int Depth = 8;

  logic       sys_clk;
  logic       sys_rst_l;
  logic       wr_enH;
  logic [7:0] wr_dataH;
  logic       flushH;
  logic       fullH;
  logic       emptyH;
  logic [3:0] countH;
  logic       xmitH;
  logic [7:0] xmit_dataH;
  logic       xmit_doneH;
  logic       ovf_flagH;

  logic txIdle   = 1'b1;
  logic holdLow  = 1'b0;
  int   busyLen  = 3;

  int total = 0;
  int bad   = 0;

  // Reference model: byte queue, transmitter-handshake flags, expected launch scoreboard.
  byte unsigned mq[$];
  byte unsigned sb[$];
  bit           mOvf     = 1'b0;
  bit           mReady   = 1'b1;
  bit           mSawBusy = 1'b0;
  bit           mPulse   = 1'b0;
  byte unsigned mData    = 8'h00;

  assign xmit_doneH = txIdle & ~holdLow;

  u_xmit_queue #(.DEPTH_LOG2(3)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .wr_enH     (wr_enH),
    .wr_dataH   (wr_dataH),
    .flushH     (flushH),
    .fullH      (fullH),
    .emptyH     (emptyH),
    .countH     (countH),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
    .ovf_flagH  (ovf_flagH)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic expOvf();
`ifdef UART_TXQ_OVF_EN
    return mOvf;
`else
    return 1'b0;
`endif
  endfunction

  // Transmitter model: goes busy for busyLen cycles after each launch pulse.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (xmitH) begin
        txIdle = 1'b0;
        repeat (busyLen) @(negedge sys_clk);
        txIdle = 1'b1;
      end
    end
  end

  // Reference model advances on each rising edge from the sampled inputs.
  initial begin
    forever begin
      @(posedge sys_clk or negedge sys_rst_l);
      if (!sys_rst_l) begin
        mq.delete();
        sb.delete();
        mOvf = 1'b0; mReady = 1'b1; mSawBusy = 1'b0; mPulse = 1'b0; mData = 8'h00;
      end else begin
        bit full;
        bit launch;
        full   = (mq.size() == Depth);
        launch = mReady && (mq.size() != 0) && xmit_doneH;
        mPulse = launch;
        if (launch) begin
          mData = mq.pop_front();
          sb.push_back(mData);
          mReady   = 1'b0;
          mSawBusy = 1'b0;
        end else if (!mReady) begin
          if (!mSawBusy && !xmit_doneH)     mSawBusy = 1'b1;
          else if (mSawBusy && xmit_doneH)  mReady   = 1'b1;
        end
        if (flushH) begin
          mq.delete();
          mOvf = 1'b0;
        end else if (wr_enH) begin
          if (!full) mq.push_back(wr_dataH);
          else       mOvf = 1'b1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_l) begin
        check("count", countH, mq.size());
        check("empty", emptyH, mq.size() == 0);
        check("full",  fullH,  mq.size() == Depth);
        check("ovf",   ovf_flagH, expOvf());
        check("xmit_pulse", xmitH, mPulse);
        check("xmit_data_hold", xmit_dataH, mData);
        if (xmitH && sb.size() != 0) begin
          byte unsigned e;
          e = sb.pop_front();
          check("launch_data", xmit_dataH, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wrByte(input byte unsigned d);
    wr_enH   = 1'b1;
    wr_dataH = d;
    tick();
    wr_enH   = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (mq.size() == 0 && sb.size() == 0 && mReady) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain_timeout", done, 1'b1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_xmit"},  xmitH, 1'b0);
    check({tag, "_data"},  xmit_dataH, 8'h00);
    check({tag, "_count"}, countH, 0);
    check({tag, "_empty"}, emptyH, 1'b1);
    check({tag, "_full"},  fullH, 1'b0);
    check({tag, "_ovf"},   ovf_flagH, 1'b0);
  endtask

  initial begin
    sys_rst_l = 1'b1;
    wr_enH    = 1'b0;
    wr_dataH  = 8'h00;
    flushH    = 1'b0;
    #2 sys_rst_l = 1'b0;
    #1 checkResetOutputs("rst_init");
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_l = 1'b1;
    tick();

    // Single byte with an idle transmitter.
    busyLen = 3;
    wrByte(8'hA5);
    repeat (10) tick();
    check("a5_empty_after", emptyH, 1'b1);
    waitDrain(200);

    // Three back-to-back bytes against a slow transmitter.
    busyLen = 160;
    wrByte(8'h01);
    wrByte(8'h02);
    wrByte(8'h03);
    waitDrain(1000);

    // Overfill while the transmitter holds done low.
    busyLen = 2;
    holdLow = 1'b1;
    for (int i = 0; i < 9; i++) wrByte(8'h10 + 8'(i));
    check("ovfl_count", countH, 8);
    check("ovfl_full",  fullH, 1'b1);
`ifdef UART_TXQ_OVF_EN
    check("ovfl_flag", ovf_flagH, 1'b1);
`else
    check("ovfl_flag", ovf_flagH, 1'b0);
`endif

    // Write coinciding with a pop while full: dropped, count falls to 7.
    holdLow = 1'b0;
    wrByte(8'hEE);
    check("full_pop_count", countH, 7);
    waitDrain(500);

    // Write and pop together at count 4: count holds.
    holdLow = 1'b1;
    for (int i = 0; i < 4; i++) wrByte(8'h40 + 8'(i));
    holdLow = 1'b0;
    wrByte(8'h44);
    check("wr_pop_count", countH, 4);
    waitDrain(500);

    // Flush while 8'h3C is in flight with 5 queued.
    busyLen = 20;
    wrByte(8'h3C);
    for (int i = 0; i < 5; i++) wrByte(8'h50 + 8'(i));
    check("pre_flush_count", countH, 5);
    flushH = 1'b1;
    tick();
    flushH = 1'b0;
    check("flush_count", countH, 0);
    repeat (40) tick();
    check("flush_inflight_data", xmit_dataH, 8'h3C);
    waitDrain(200);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      wr_enH   = ($urandom_range(0, 2) != 0);
      wr_dataH = 8'($urandom);
      flushH   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) holdLow = ~holdLow;
      busyLen  = $urandom_range(1, 6);
      tick();
    end
    wr_enH  = 1'b0;
    flushH  = 1'b0;
    holdLow = 1'b0;
    waitDrain(2000);

    // Asynchronous reset in the middle of a queue.
    holdLow = 1'b1;
    for (int i = 0; i < 3; i++) wrByte(8'h70 + 8'(i));
    @(posedge sys_clk);
    #3 sys_rst_l = 1'b0;
    #1 checkResetOutputs("rst_mid");
    #2 sys_rst_l = 1'b1;
    holdLow = 1'b0;
    repeat (30) tick();
    check("post_reset_empty", emptyH, 1'b1);
    check("post_reset_no_launch", xmit_dataH, 8'h00);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
